// File: rtl/sr_ff_bank.sv
`default_nettype none
// ============================================================================
// Module   : sr_ff_bank
// Brief    : Bank of WIDTH independent bit-cells, each run-time selectable as
//            an SR, JK, D or T flip-flop. SR S=R=1 resolves by a fixed policy
//            and is logged in sticky per-channel flags plus a saturating
//            event counter.
// Revision : 1.0 - initial release
// ============================================================================
module sr_ff_bank #(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               SR_POLICY = 0,
  parameter int               CNT_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             err_clr,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn,
  output logic [WIDTH-1:0] err,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [1:0] MODE_SR = 2'b00;
  localparam logic [1:0] MODE_JK = 2'b01;
  localparam logic [1:0] MODE_D  = 2'b10;
  localparam logic [1:0] MODE_T  = 2'b11;

  // Unsupported policy values fall back to hold.
  localparam int POLICY = ((SR_POLICY == 1) || (SR_POLICY == 2)) ? SR_POLICY : 0;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] illegal;
  logic             any_illegal;

  // Next state of one cell for the selected flip-flop personality.
  function automatic logic cell_next(input logic [1:0] m, input logic ai,
                                     input logic bi, input logic qi);
    logic r;
    r = qi;
    case (m)
      MODE_SR: begin
        case ({ai, bi})
          2'b01:   r = 1'b0;
          2'b10:   r = 1'b1;
          2'b11:   r = (POLICY == 1) ? 1'b1 : ((POLICY == 2) ? 1'b0 : qi);
          default: r = qi;
        endcase
      end
      MODE_JK: begin
        case ({ai, bi})
          2'b01:   r = 1'b0;
          2'b10:   r = 1'b1;
          2'b11:   r = ~qi;
          default: r = qi;
        endcase
      end
      MODE_D:  r = ai;
      MODE_T:  r = qi ^ ai;
      default: r = qi;
    endcase
    return r;
  endfunction

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    assign q_next[i] = cell_next(mode, a[i], b[i], q[i]);
  end

  // Illegal only counts on an enabled SR-mode cycle.
  assign illegal     = (en && (mode == MODE_SR)) ? (a & b) : '0;
  assign any_illegal = |illegal;

  // Flip-flop state; reset dominates, enable gates all updates.
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= RESET_VAL;
    end else if (en) begin
      q <= q_next;
    end
  end

  // Complement derived from the register, so it tracks q even during reset.
  assign qn = ~q;

  // Sticky flags and saturating counter; a new illegal beats a clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      err     <= '0;
      err_cnt <= '0;
    end else if (err_clr) begin
      err     <= illegal;
      err_cnt <= any_illegal ? CNT_ONE : '0;
    end else begin
      err <= err | illegal;
      if (any_illegal && (err_cnt != CNT_MAX)) begin
        err_cnt <= err_cnt + CNT_ONE;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/sr_ff_bank.md
Name: sr_ff_bank

Overview:
- Parametrised bank of WIDTH independent bit-cells sharing one clock, one reset and one run-time mode select.
- Each cell can act as an SR, JK, D or T flip-flop.
- The SR illegal input (S=R=1) never drives high-impedance. It resolves by a fixed policy and is logged in sticky per-channel error flags and a saturating event counter.
- Used as the general-purpose control/flag register primitive in place of single-bit SR flip-flops.

Parameters:
- WIDTH, 4: number of independent flip-flop channels (at least 1).
- RESET_VAL, 0: WIDTH-bit value loaded into q on reset.
- SR_POLICY, 0: resolution of S=R=1 in SR mode. 0 = hold, 1 = set-dominant, 2 = reset-dominant. Any other value is treated as 0.
- CNT_W, 8: width of the illegal-event counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset; highest priority.
- en  in  1  clock enable; when 0, q, err and err_cnt hold.
- mode  in  2  00 = SR, 01 = JK, 10 = D, 11 = T; sampled every enabled edge.
- a  in  WIDTH  per-channel first input: S / J / D / T.
- b  in  WIDTH  per-channel second input: R / K; ignored in D and T modes.
- err_clr  in  1  clears err and err_cnt; acts regardless of en.
- q  out  WIDTH  registered flip-flop state.
- qn  out  WIDTH  registered complement; always equals ~q, including during reset.
- err  out  WIDTH  sticky flag per channel: S=R=1 seen in SR mode.
- err_cnt  out  CNT_W  count of enabled SR-mode cycles with at least one illegal channel; saturates at all-ones.

Behaviour:
Reset and latency
- Reset on a rising edge with reset=1: q=RESET_VAL, qn=~RESET_VAL, err=0, err_cnt=0.
- Reset overrides en, err_clr and all inputs.
- Reset mid-operation discards the in-flight update; the next non-reset edge computes from RESET_VAL.
- Latency: inputs sampled at edge N appear on q/qn/err/err_cnt right after edge N. No combinational path from inputs to outputs.

Per-channel next state when en=1, where a_i/b_i are the channel inputs and q_i is the current state:
- SR mode: 00 hold; 01 q=0; 10 q=1. For 11, SR_POLICY 0 holds, 1 gives q=1, 2 gives q=0.
- JK mode: 00 hold; 01 q=0; 10 q=1; 11 q=~q_i.
- D mode: q=a_i.
- T mode: q = q_i xor a_i.
- en=0: q holds in every mode.

Illegal detection
- Channel i is illegal in a cycle when en=1, mode=00, a_i=1 and b_i=1.
- JK/D/T never flag.

err (per channel)
- err_i is set on an illegal cycle and cleared only by err_clr or reset.
- err_clr and a new illegal in the same cycle: the set wins, err_i=1.
- Channels not illegal in an err_clr cycle clear to 0.

err_cnt
- Increments by 1 per illegal cycle, regardless of how many channels are illegal.
- Holds at 2^CNT_W-1 once saturated.
- err_clr alone gives 0. err_clr together with an illegal cycle gives 1.

Mode changes
- Take effect on the same edge they are sampled; no pipeline or settling cycle.
- q carries over unchanged into the new mode.

Test Plan:
Parameters for all scenarios: WIDTH=4, RESET_VAL=4'b1010, SR_POLICY=0, CNT_W=2.
1. Reset plus SR basics.
   - reset 1 cycle -> q=1010, qn=0101, err=0, err_cnt=0.
   - mode=00, a=0001, b=0010 -> q=1001.
   - a=b=0 for 3 cycles -> q stays 1001.
2. SR illegal policy and saturation.
   - a=1100, b=0100 -> q=1001 (ch2 holds at 0, ch3 set), err=0100, err_cnt=1.
   - Repeat 4 more cycles -> err_cnt saturates at 3.
   - Rerun with SR_POLICY=1 -> ch2 becomes 1. Rerun with SR_POLICY=2 -> ch2 becomes 0.
3. Clear race.
   - From err=0100, err_clr=1 with a=b=0001 in SR mode -> err=0001, err_cnt=1.
   - Next cycle err_clr only -> err=0000, err_cnt=0.
4. JK/T toggling.
   - q=0000, mode=01, a=b=1111 for 2 cycles -> q=1111 then 0000, err stays 0.
   - mode=11, a=0101 -> q=0101.
5. D mode and enable.
   - mode=10, a=0110, b=1111 -> q=0110.
   - en=0 with a=1001 and mode=00, a=b=1111 -> q=0110, err=0, err_cnt unchanged.
6. Reset mid-operation.
   - mode=01, a=b=1111, assert reset and err_clr together -> q=1010 on that edge.
   - Release reset -> next edge q=0101.
